// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED I2C write path.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_BUF,
    ST_DONE
  } state_t;

  localparam logic [7:0] OLED_ADDR      = 8'h78;
  localparam logic [7:0] CTRL_CMD       = 8'h00;
  localparam logic [7:0] CTRL_DATA      = 8'h40;
  localparam int         CELLS_PER_WORD = 30;

endpackage

// File: rtl/iic_qtick_gen.sv
// Quarter-SCL-period tick generator; counter parks at zero while disabled
// so the first quarter of every word is a full DIV cycles long.
module iic_qtick_gen #(
  parameter int DIV = 31
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  output logic qtick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/oled_iic_writer.sv
// I2C master that sends one {addr, control, payload} word per request as a
// single write transaction, then pulses write_done after the bus-free cell.
//   state | meaning
//   IDLE  | bus released, waiting for wr_req; latches word on request
//   START | one cell, SDA falls while SCL high
//   BYTE  | 3 bytes x 9 cells (8 data MSB first + ACK slot)
//   STOP  | one cell, SDA rises while SCL high
//   BUF   | one idle cell of bus-free time
//   DONE  | single cycle, write_done pulse
module oled_iic_writer
  import oled_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [23:0] wr_data,
  output logic        write_done,
  output logic        busy,
  output logic        ack_err,
  output logic        iic_scl,
  inout  wire         iic_sda
);

  localparam int DIV = CLK_FREQ / (4 * IIC_FREQ);

  state_t      state, state_nx;
  logic [1:0]  q;
  logic [3:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic        qtick;
  logic        cell_end;
  logic        sda_low;
  logic        scl_nx;
  logic        sda_low_nx;

  iic_qtick_gen #(.DIV(DIV)) u_qtick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      ((state != ST_IDLE) && (state != ST_DONE)),
    .qtick   (qtick)
  );

  assign cell_end = qtick && (q == 2'd3);
  assign iic_sda  = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    state_nx   = state;
    scl_nx     = 1'b1;
    sda_low_nx = 1'b0;
    case (state)
      ST_IDLE:  if (wr_req) state_nx = ST_START;
      ST_START: begin
        sda_low_nx = q[1];
        if (cell_end) state_nx = ST_BYTE;
      end
      ST_BYTE: begin
        scl_nx     = (q == 2'd1) || (q == 2'd2);
        sda_low_nx = (bit_idx != 4'd8) && !shreg[23];
        if (cell_end && bit_idx == 4'd8 && byte_idx == 2'd2) state_nx = ST_STOP;
      end
      ST_STOP: begin
        scl_nx     = (q != 2'd0);
        sda_low_nx = !q[1];
        if (cell_end) state_nx = ST_BUF;
      end
      ST_BUF:   if (cell_end) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      q          <= 2'd0;
      bit_idx    <= 4'd0;
      byte_idx   <= 2'd0;
      shreg      <= 24'd0;
      ack_err    <= 1'b0;
      busy       <= 1'b0;
      write_done <= 1'b0;
      iic_scl    <= 1'b1;
      sda_low    <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != ST_IDLE);
      write_done <= (state_nx == ST_DONE);
      iic_scl    <= scl_nx;
      sda_low    <= sda_low_nx;
      if (state == ST_IDLE && wr_req) begin
        shreg    <= wr_data;
        ack_err  <= 1'b0;
        q        <= 2'd0;
        bit_idx  <= 4'd0;
        byte_idx <= 2'd0;
      end
      if (qtick) begin
        q <= q + 2'd1;
        // ACK is read on the tick that ends q1, i.e. the start of q2
        if (state == ST_BYTE && q == 2'd1 && bit_idx == 4'd8 && iic_sda) ack_err <= 1'b1;
        if (state == ST_BYTE && q == 2'd3) begin
          if (bit_idx == 4'd8) begin
            bit_idx <= 4'd0;
            if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            shreg   <= {shreg[22:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_iic_writer.sv
// Bench for oled_iic_writer: I2C slave monitor plus cycle-level latency model.
module tb_oled_iic_writer;
  import oled_pkg::*;

  localparam int CLK_FREQ = 4_000_000;
  localparam int IIC_FREQ = 500_000;
  localparam int DIV      = CLK_FREQ / (4 * IIC_FREQ);
  localparam int LAT      = CELLS_PER_WORD * 4 * DIV + 1;
  localparam int NRAND    = 150;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_req  = 1'b0;
  logic [23:0] wr_data = 24'd0;
  logic        write_done, busy, ack_err, iic_scl;
  wire         sda_bus;
  logic        bfm_pull = 1'b0;

  pullup (sda_bus);
  assign sda_bus = bfm_pull ? 1'b0 : 1'bz;

  always #125 sys_clk = ~sys_clk;

  oled_iic_writer #(.CLK_FREQ(CLK_FREQ), .IIC_FREQ(IIC_FREQ)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .write_done (write_done),
    .busy       (busy),
    .ack_err    (ack_err),
    .iic_scl    (iic_scl),
    .iic_sda    (sda_bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic        nack_q[$];
  int          rem      = 0;
  int          wd_count = 0;

  // Reference timing: a word is taken in any idle cycle with wr_req high,
  // and completes exactly LAT cycles later.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      rem = 0;
    end else if (rem > 0) begin
      rem--;
      check("busy_active", busy, 1);
      check("write_done", write_done, rem == 0);
      if (rem == LAT - 1) check("ack_err_clear", ack_err, 0);
      if (rem == 0) begin
        wd_count++;
        check("nack_record", nack_q.size(), 1);
        if (nack_q.size() > 0) check("ack_err", ack_err, nack_q.pop_front());
      end
    end else begin
      check("busy_idle", busy, 0);
      check("write_done_idle", write_done, 0);
      if (wr_req) begin
        exp_q.push_back(wr_data);
        rem = LAT;
      end
    end
  end

  // Slave monitor: decodes START/bits/STOP, ACKs per nack_mask, checks idle bus.
  logic        scl_p = 1'b1, sda_p = 1'b1;
  bit          in_frame = 0, fnack = 0, have_stop = 0, rand_nack = 0, expect_abort = 0;
  int          nbit = 0;
  logic [23:0] sh = 24'd0;
  longint      stop_cyc = 0;
  logic [2:0]  nack_mask = 3'b000;

  always @(negedge sys_clk) begin
    bit n;
    if (expect_abort || !rst_n) begin
      in_frame = 0;
      bfm_pull = 1'b0;
    end else if (scl_p && iic_scl && sda_p !== sda_bus) begin
      if (!sda_bus) begin
        check("start_in_frame", in_frame, 0);
        if (have_stop) check("bus_free_gap", (cyc - stop_cyc) >= 4 * DIV, 1);
        in_frame = 1; nbit = 0; sh = 24'd0; fnack = 0;
      end else begin
        check("stop_in_frame", in_frame, 1);
        check("stop_bit_count", nbit, 28);
        if (in_frame) begin
          got_q.push_back(sh);
          nack_q.push_back(fnack);
          check("exp_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) check("bus_word", sh, exp_q.pop_front());
        end
        in_frame = 0; have_stop = 1; stop_cyc = cyc;
      end
    end else if (!in_frame) begin
      check("idle_bus", {iic_scl, sda_bus}, 2'b11);
    end else if (!scl_p && iic_scl) begin
      if (nbit < 27 && nbit % 9 != 8) sh = {sh[22:0], sda_bus};
      nbit++;
    end else if (scl_p && !iic_scl) begin
      if (nbit % 9 == 8) begin
        n = nack_mask[nbit / 9] || (rand_nack && $urandom_range(0, 7) == 0);
        fnack = fnack | n;
        bfm_pull = !n;
      end else if (nbit > 0 && nbit % 9 == 0) begin
        bfm_pull = 1'b0;
      end
    end
    scl_p = iic_scl;
    sda_p = sda_bus;
  end

  typedef struct {
    logic [23:0] word;
    logic [2:0]  nack;
    logic        exp_ack_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge sys_clk);
      if (write_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit     ok;
    longint t0;
    got_q.delete();
    nack_mask = v.nack;
    tick();
    wr_data = v.word;
    wr_req  = 1'b1;
    @(negedge sys_clk);
    t0 = cyc;
    tick();
    wr_req = 1'b0;
    wait_done(ok);
    check("vec_done", ok, 1);
    check("vec_latency", 32'(cyc - t0), LAT);
    check("vec_ack_err", ack_err, v.exp_ack_err);
    @(negedge sys_clk);
    check("vec_busy_fall", busy, 0);
    check("vec_words", got_q.size(), 1);
    if (got_q.size() > 0) check("vec_word", got_q[0], v.word);
    nack_mask = 3'b000;
  endtask

  initial begin
    bit ok;
    int w0;
    logic [23:0] w;

    vecs[0] = '{{OLED_ADDR, CTRL_CMD,  8'hAE}, 3'b000, 1'b0};
    vecs[1] = '{{OLED_ADDR, CTRL_DATA, 8'hFF}, 3'b100, 1'b1};
    vecs[2] = '{{OLED_ADDR, CTRL_CMD,  8'h8D}, 3'b000, 1'b0};
    vecs[3] = '{{OLED_ADDR, CTRL_DATA, 8'h00}, 3'b001, 1'b1};
    vecs[4] = '{{OLED_ADDR, CTRL_DATA, 8'hA5}, 3'b010, 1'b1};
    vecs[5] = '{{8'h3C,     8'h5A,     8'h81}, 3'b000, 1'b0};

    repeat (3) @(negedge sys_clk);
    check("rst_scl", iic_scl, 1);
    check("rst_sda", sda_bus, 1);
    check("rst_busy", busy, 0);
    check("rst_done", write_done, 0);
    check("rst_ack_err", ack_err, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-to-back with the upstream index advancing on write_done
    got_q.delete();
    tick();
    wr_data = {OLED_ADDR, CTRL_DATA, 8'h01};
    wr_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(ok);
      check("b2b_done", ok, 1);
      tick();
      if (k < 2) wr_data = {OLED_ADDR, CTRL_DATA, 8'(k + 2)};
      else wr_req = 1'b0;
    end
    repeat (5) @(negedge sys_clk);
    check("b2b_count", got_q.size(), 3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      check("b2b_word", got_q[k], {OLED_ADDR, CTRL_DATA, 8'(k + 1)});

    // inputs scrambled while the word is in flight
    got_q.delete();
    w0 = wd_count;
    w  = {OLED_ADDR, CTRL_CMD, 8'hC8};
    tick();
    wr_data = w;
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    repeat (30) tick();
    for (int i = 0; i < 80; i++) begin
      tick();
      wr_data = 24'($urandom);
      wr_req  = 1'($urandom_range(0, 1));
    end
    wr_req = 1'b0;
    wait_done(ok);
    check("scr_done", ok, 1);
    repeat (20) @(negedge sys_clk);
    check("scr_words", got_q.size(), 1);
    if (got_q.size() > 0) check("scr_word", got_q[0], w);
    check("scr_pulses", wd_count - w0, 1);

    // reset in the middle of the second byte
    tick();
    wr_data = {OLED_ADDR, CTRL_CMD, 8'h00};
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    repeat (83) tick();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_sda", sda_bus, 0);
    expect_abort = 1;
    rst_n = 1'b0;
    #1;
    check("arst_scl", iic_scl, 1);
    check("arst_sda", sda_bus, 1);
    check("arst_busy", busy, 0);
    check("arst_done", write_done, 0);
    exp_q.delete();
    w0 = wd_count;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    expect_abort = 0;
    repeat (300) tick();
    check("arst_no_done", wd_count - w0, 0);
    run_vec(vecs[0]);

    // randomized traffic with random NACKs
    rand_nack = 1;
    w0 = wd_count;
    for (int i = 0; i < NRAND * (LAT + 10) && (wd_count - w0) < NRAND; i++) begin
      tick();
      wr_req  = ($urandom_range(0, 3) != 0);
      wr_data = ($urandom_range(0, 3) == 0) ? 24'($urandom)
              : {OLED_ADDR, ($urandom_range(0, 1) ? CTRL_DATA : CTRL_CMD), 8'($urandom)};
    end
    wr_req = 1'b0;
    for (int i = 0; i < LAT + 20 && rem > 0; i++) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    check("rand_progress", (wd_count - w0) >= NRAND, 1);
    check("rand_drained", rem, 0);
    check("rand_exp_left", exp_q.size(), 0);
    check("rand_nack_left", nack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
